pixel_sensor_sequencer: RTL and testbench

//  Frame-level controller for the pixel array. Drives the shared ERASE/EXPOSE/RAMP lines
//  of every PIXEL_SENSOR_ANALOG instance through erase -> expose -> convert, then

---
 rtl/pixel_sensor_sequencer_pkg.sv | 26 ++
 rtl/sequencer_phase_timer.sv | 29 ++
 rtl/pixel_sensor_sequencer.sv | 176 +++++++++++++++++
 tb/tb_pixel_sensor_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_sensor_sequencer_pkg.sv
// Shared constants and state encoding for the pixel-array frame sequencer.
// Array geometry matches the analog pixel instances the sequencer drives.
package pixel_sensor_sequencer_pkg;

    localparam int PIXEL_BITS           = 8;
    localparam int PIXEL_ARRAY_HEIGHT   = 24;
    localparam int ERASE_CYCLES_DEFAULT = 4;
    localparam int RAMP_PULSES          = 2 ** PIXEL_BITS;
    localparam int EXPOSE_BITS_DEFAULT  = 16;

    // Enum literals carry an ST_ prefix so they never collide with the
    // ERASE/EXPOSE array-line ports of the top module.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4,
        ST_DONE    = 3'd5
    } sequencer_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sequencer_phase_timer.sv
// Loadable down-counter shared by the ERASE, EXPOSE and CONVERT phases.
// Stops at zero (no wrap); a load takes priority over counting.
module sequencer_phase_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] value_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_value;
        end else if (value_reg != '0) begin
            value_reg <= value_reg - 1'b1;
        end
    end

    assign value = value_reg;
    assign zero  = (value_reg == '0);

endmodule

// File: rtl/pixel_sensor_sequencer.sv
// Frame controller for the pixel array: erase -> expose -> convert on the shared
// array lines, then row-by-row readout with a valid/ready handshake.
module pixel_sensor_sequencer
    import pixel_sensor_sequencer_pkg::*;
#(
    parameter int ERASE_CYCLES = ERASE_CYCLES_DEFAULT,
    parameter int RAMP_PULSES  = pixel_sensor_sequencer_pkg::RAMP_PULSES,
    parameter int ROWS         = PIXEL_ARRAY_HEIGHT,
    parameter int EXPOSE_BITS  = EXPOSE_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [EXPOSE_BITS-1:0]  expose_time,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    ERASE,
    output logic                    EXPOSE,
    output logic                    RAMP,
    output logic [$clog2(ROWS)-1:0] row_sel,
    output logic                    read_valid,
    input  logic                    read_ready
);

    localparam int TIMER_W = max_int($clog2(2 * RAMP_PULSES), EXPOSE_BITS);
    localparam int ROW_W   = $clog2(ROWS);

    localparam logic [TIMER_W-1:0] ERASE_LOAD   = TIMER_W'(ERASE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CONVERT_LOAD = TIMER_W'(2 * RAMP_PULSES - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW     = ROW_W'(ROWS - 1);

    sequencer_state_t state_reg, state_next;

    logic [EXPOSE_BITS-1:0] expose_time_reg;
    logic                   expose_latch;
    logic                   busy_reg, busy_next;
    logic                   frame_done_reg, frame_done_next;
    logic                   erase_reg, erase_next;
    logic                   expose_reg, expose_next;
    logic                   ramp_reg, ramp_next;
    logic                   read_valid_reg, read_valid_next;
    logic [ROW_W-1:0]       row_sel_reg, row_sel_next;

    logic                   timer_load;
    logic [TIMER_W-1:0]     timer_load_value;
    logic [TIMER_W-1:0]     timer_value;
    logic                   timer_zero;

    sequencer_phase_timer #(
        .WIDTH (TIMER_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            expose_time_reg <= '0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
            erase_reg       <= 1'b0;
            expose_reg      <= 1'b0;
            ramp_reg        <= 1'b0;
            read_valid_reg  <= 1'b0;
            row_sel_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            if (expose_latch) begin
                expose_time_reg <= expose_time;
            end
            busy_reg        <= busy_next;
            frame_done_reg  <= frame_done_next;
            erase_reg       <= erase_next;
            expose_reg      <= expose_next;
            ramp_reg        <= ramp_next;
            read_valid_reg  <= read_valid_next;
            row_sel_reg     <= row_sel_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        expose_latch     = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = '0;
        frame_done_next  = 1'b0;
        erase_next       = 1'b0;
        expose_next      = 1'b0;
        ramp_next        = 1'b0;
        read_valid_next  = 1'b0;
        row_sel_next     = row_sel_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next       = ST_ERASE;
                    expose_latch     = 1'b1;
                    timer_load       = 1'b1;
                    timer_load_value = ERASE_LOAD;
                    erase_next       = 1'b1;
                end
            end
            ST_ERASE: begin
                if (!timer_zero) begin
                    erase_next = 1'b1;
                end else if (expose_time_reg == '0) begin
                    state_next       = ST_CONVERT;
                    timer_load       = 1'b1;
                    timer_load_value = CONVERT_LOAD;
                    ramp_next        = 1'b1;
                end else begin
                    state_next       = ST_EXPOSE;
                    timer_load       = 1'b1;
                    timer_load_value = TIMER_W'(expose_time_reg) - TIMER_W'(1);
                    expose_next      = 1'b1;
                end
            end
            ST_EXPOSE: begin
                if (!timer_zero) begin
                    expose_next = 1'b1;
                end else begin
                    state_next       = ST_CONVERT;
                    timer_load       = 1'b1;
                    timer_load_value = CONVERT_LOAD;
                    ramp_next        = 1'b1;
                end
            end
            ST_CONVERT: begin
                // The convert load is odd, so RAMP is high exactly when the
                // timer is odd; the last (timer==0) cycle is always low.
                if (!timer_zero) begin
                    ramp_next = ~timer_value[0];
                end else begin
                    state_next      = ST_READ;
                    read_valid_next = 1'b1;
                    row_sel_next    = '0;
                end
            end
            ST_READ: begin
                read_valid_next = 1'b1;
                if (read_valid_reg && read_ready) begin
                    if (row_sel_reg == LAST_ROW) begin
                        state_next      = ST_DONE;
                        read_valid_next = 1'b0;
                        frame_done_next = 1'b1;
                        row_sel_next    = '0;
                    end else begin
                        row_sel_next = row_sel_reg + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign ERASE      = erase_reg;
    assign EXPOSE     = expose_reg;
    assign RAMP       = ramp_reg;
    assign read_valid = read_valid_reg;
    assign row_sel    = row_sel_reg;

endmodule

// File: tb/tb_pixel_sensor_sequencer.sv
// Self-checking bench for pixel_sensor_sequencer with a small behavioural
// model of a 2x2 pixel array hanging off the ERASE/EXPOSE/RAMP lines.
module tb_pixel_sensor_sequencer;

    localparam int ROWS       = 24;
    localparam int ERASE_N    = 4;
    localparam int RAMP_N     = 256;
    localparam int FRAME_WAIT = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] expose_time;
    logic        busy;
    logic        frame_done;
    logic        erase_line;
    logic        expose_line;
    logic        ramp_line;
    logic [4:0]  row_sel;
    logic        read_valid;
    logic        read_ready;

    int errors = 0;
    int checks = 0;
    int exp_rows[$];

    int m_erase_cnt, m_expose_cnt, m_ramp_edges, m_hs_cnt, m_overlap;
    int m_first_erase, m_last_erase, m_first_expose, m_first_ramp;
    int m_first_valid, m_done_rel;
    logic [3:0] m_cmp_expose, m_cmp_read;

    pixel_sensor_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .expose_time (expose_time),
        .busy        (busy),
        .frame_done  (frame_done),
        .ERASE       (erase_line),
        .EXPOSE      (expose_line),
        .RAMP        (ramp_line),
        .row_sel     (row_sel),
        .read_valid  (read_valid),
        .read_ready  (read_ready)
    );

    always #5 clk = ~clk;

    // 2x2 pixel model: ERASE clears, EXPOSE integrates light, each RAMP edge
    // advances the shared code and trips CMP once code reaches the charge.
    int         px_light [4] = '{1, 5, 20, 0};
    int         px_charge [4] = '{0, 0, 0, 0};
    int         px_code = 0;
    logic [3:0] px_cmp = 4'h0;
    logic       px_ramp_q = 1'b0;

    always @(posedge clk) begin
        px_ramp_q <= ramp_line;
        if (erase_line === 1'b1) begin
            px_code <= 0;
            px_cmp  <= 4'h0;
            for (int i = 0; i < 4; i++) px_charge[i] <= 0;
        end else begin
            if (expose_line === 1'b1) begin
                for (int i = 0; i < 4; i++)
                    px_charge[i] <= (px_charge[i] + px_light[i] > 255) ? 255 : px_charge[i] + px_light[i];
            end
            if (ramp_line === 1'b1 && px_ramp_q === 1'b0) begin
                px_code <= px_code + 1;
                for (int i = 0; i < 4; i++)
                    if (px_code + 1 >= px_charge[i]) px_cmp[i] <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from a start pulse, measuring line activity relative to
    // the start cycle (rel 0) and scoreboarding every row handshake.
    task automatic run_frame(input logic [15:0] e, input bit rand_ready,
                             input bit hold_start, input bit busy_start);
        logic prev_ramp;
        bit   holding;
        logic [4:0] held_row;
        int   want;
        prev_ramp = 1'b0;
        holding = 1'b0;
        held_row = '0;
        exp_rows.delete();
        for (int r = 0; r < ROWS; r++) exp_rows.push_back(r);
        m_erase_cnt = 0; m_expose_cnt = 0; m_ramp_edges = 0; m_hs_cnt = 0; m_overlap = 0;
        m_first_erase = -1; m_last_erase = -1; m_first_expose = -1; m_first_ramp = -1;
        m_first_valid = -1; m_done_rel = -1;
        m_cmp_expose = 4'hx; m_cmp_read = 4'hx;
        start = 1'b1;
        expose_time = e;
        read_ready = 1'b1;
        for (int rel = 1; rel <= FRAME_WAIT && m_done_rel < 0; rel++) begin
            tick();
            if (!hold_start) start = 1'b0;
            if (busy_start && rel == 3) begin
                start = 1'b1;
                expose_time = 16'd99;
            end
            if (int'(erase_line) + int'(expose_line) + int'(ramp_line) > 1) m_overlap++;
            if (erase_line) begin
                if (m_first_erase < 0) m_first_erase = rel;
                m_last_erase = rel;
                m_erase_cnt++;
            end
            if (expose_line) begin
                if (m_first_expose < 0) begin
                    m_first_expose = rel;
                    m_cmp_expose = px_cmp;
                end
                m_expose_cnt++;
            end
            if (ramp_line && !prev_ramp) begin
                if (m_first_ramp < 0) m_first_ramp = rel;
                m_ramp_edges++;
            end
            prev_ramp = ramp_line;
            if (holding && read_valid) begin
                checks++;
                if (row_sel !== held_row) begin
                    errors++;
                    $display("FAIL row_hold rel=%0d got=%0d want=%0d", rel, row_sel, held_row);
                end
            end
            holding = 1'b0;
            if (read_valid && m_first_valid < 0) begin
                m_first_valid = rel;
                m_cmp_read = px_cmp;
            end
            read_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (read_valid) begin
                if (read_ready) begin
                    checks++;
                    if (exp_rows.size() == 0) begin
                        errors++;
                        $display("FAIL extra_handshake rel=%0d row=%0d want=none", rel, row_sel);
                    end else begin
                        want = exp_rows.pop_front();
                        if (row_sel !== 5'(want)) begin
                            errors++;
                            $display("FAIL row_order rel=%0d got=%0d want=%0d", rel, row_sel, want);
                        end
                    end
                    m_hs_cnt++;
                end else begin
                    holding = 1'b1;
                    held_row = row_sel;
                end
            end
            if (frame_done) begin
                m_done_rel = rel;
                checks++;
                if (row_sel !== 5'd0) begin
                    errors++;
                    $display("FAIL row_sel_at_done got=%0d want=0", row_sel);
                end
            end
        end
        checks++;
        if (m_done_rel < 0) begin
            errors++;
            $display("FAIL frame_timeout got=no frame_done want=frame_done within %0d cycles", FRAME_WAIT);
        end
        start = 1'b0;
        read_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        expose_time = 16'd5;
        read_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({busy, frame_done, erase_line, expose_line, ramp_line, read_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {busy, frame_done, erase_line, expose_line, ramp_line, read_valid});
        end
        checks++;
        if (row_sel !== 5'd0) begin
            errors++;
            $display("FAIL reset_row_sel got=%0d want=0", row_sel);
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy got=%b want=0", busy);
        end
        $display("test_reset: errors=%0d", errors);
    endtask

    task automatic test_nominal_frame();
        run_frame(16'd10, 1'b0, 1'b0, 1'b0);
        checks++; if (m_first_erase !== 1) begin errors++; $display("FAIL first_erase got=%0d want=1", m_first_erase); end
        checks++; if (m_erase_cnt !== ERASE_N) begin errors++; $display("FAIL erase_cycles got=%0d want=%0d", m_erase_cnt, ERASE_N); end
        checks++; if (m_first_expose !== 5) begin errors++; $display("FAIL first_expose got=%0d want=5", m_first_expose); end
        checks++; if (m_expose_cnt !== 10) begin errors++; $display("FAIL expose_cycles got=%0d want=10", m_expose_cnt); end
        checks++; if (m_first_ramp !== 15) begin errors++; $display("FAIL first_ramp got=%0d want=15", m_first_ramp); end
        checks++; if (m_ramp_edges !== RAMP_N) begin errors++; $display("FAIL ramp_edges got=%0d want=%0d", m_ramp_edges, RAMP_N); end
        checks++; if (m_first_valid !== 1 + 4 + 10 + 512) begin errors++; $display("FAIL first_valid got=%0d want=527", m_first_valid); end
        checks++; if (m_hs_cnt !== ROWS) begin errors++; $display("FAIL handshakes got=%0d want=%0d", m_hs_cnt, ROWS); end
        checks++; if (m_done_rel + 1 !== 1 + 4 + 10 + 512 + 24 + 1) begin errors++; $display("FAIL frame_cycles got=%0d want=552", m_done_rel + 1); end
        checks++; if (m_overlap !== 0) begin errors++; $display("FAIL line_overlap got=%0d want=0", m_overlap); end
        tick();
        checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b%b want=00", frame_done, busy); end
        $display("test_nominal_frame: done_rel=%0d errors=%0d", m_done_rel, errors);
    endtask

    task automatic test_pixel_array();
        checks++;
        if (px_cmp !== 4'hF) begin errors++; $display("FAIL cmp_before_frame got=%h want=f", px_cmp); end
        run_frame(16'd10, 1'b0, 1'b0, 1'b0);
        checks++; if (m_cmp_expose !== 4'h0) begin errors++; $display("FAIL cmp_erased got=%h want=0", m_cmp_expose); end
        checks++; if (m_cmp_read !== 4'hF) begin errors++; $display("FAIL cmp_at_read got=%h want=f", m_cmp_read); end
        $display("test_pixel_array: errors=%0d", errors);
    endtask

    task automatic test_zero_expose();
        tick();
        run_frame(16'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (m_expose_cnt !== 0) begin errors++; $display("FAIL zero_expose_cycles got=%0d want=0", m_expose_cnt); end
        checks++; if (m_first_ramp !== m_last_erase + 1 || m_last_erase !== 4) begin
            errors++; $display("FAIL convert_after_erase got=%0d want=5", m_first_ramp); end
        checks++; if (m_first_valid !== 1 + 4 + 512) begin errors++; $display("FAIL zero_first_valid got=%0d want=517", m_first_valid); end
        checks++; if (m_ramp_edges !== RAMP_N) begin errors++; $display("FAIL zero_ramp_edges got=%0d want=%0d", m_ramp_edges, RAMP_N); end
        $display("test_zero_expose: errors=%0d", errors);
    endtask

    task automatic test_random_ready();
        tick();
        run_frame(16'd3, 1'b1, 1'b0, 1'b0);
        checks++; if (m_hs_cnt !== ROWS) begin errors++; $display("FAIL rand_handshakes got=%0d want=%0d", m_hs_cnt, ROWS); end
        checks++; if (exp_rows.size() !== 0) begin errors++; $display("FAIL rows_left got=%0d want=0", exp_rows.size()); end
        checks++; if (m_done_rel < m_first_valid + ROWS) begin errors++; $display("FAIL rand_done_too_early got=%0d want>=%0d", m_done_rel, m_first_valid + ROWS); end
        $display("test_random_ready: done_rel=%0d errors=%0d", m_done_rel, errors);
    endtask

    task automatic test_start_while_busy();
        tick();
        run_frame(16'd10, 1'b0, 1'b0, 1'b1);
        checks++; if (m_expose_cnt !== 10) begin errors++; $display("FAIL busy_start_expose got=%0d want=10", m_expose_cnt); end
        checks++; if (m_done_rel + 1 !== 552) begin errors++; $display("FAIL busy_start_frame got=%0d want=552", m_done_rel + 1); end
        tick(); tick();
        checks++; if (busy !== 1'b0 || erase_line !== 1'b0) begin errors++; $display("FAIL start_queued got=%b%b want=00", busy, erase_line); end
        $display("test_start_while_busy: errors=%0d", errors);
    endtask

    task automatic test_reset_mid_convert();
        int edges;
        logic prev;
        edges = 0;
        prev = 1'b0;
        start = 1'b1; expose_time = 16'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && edges < 5; i++) begin
            tick();
            if (ramp_line && !prev) edges++;
            prev = ramp_line;
        end
        checks++; if (edges !== 5) begin errors++; $display("FAIL convert_reached got=%0d edges want=5", edges); end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, frame_done, erase_line, expose_line, ramp_line, read_valid, row_sel} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid_convert got=%b want=0",
                     {busy, frame_done, erase_line, expose_line, ramp_line, read_valid, row_sel});
        end
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0 || erase_line !== 1'b0) begin errors++; $display("FAIL idle_after_abort got=%b%b want=00", busy, erase_line); end
        $display("test_reset_mid_convert: errors=%0d", errors);
    endtask

    task automatic test_reset_mid_read();
        int waited;
        waited = 0;
        start = 1'b1; expose_time = 16'd0; read_ready = 1'b0;
        tick();
        start = 1'b0;
        while (!read_valid && waited < 700) begin
            tick();
            waited++;
        end
        checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL read_reached got=%b want=1", read_valid); end
        tick(); tick();
        checks++; if (row_sel !== 5'd0 || read_valid !== 1'b1) begin errors++; $display("FAIL stall_row got=%0d want=0", row_sel); end
        read_ready = 1'b1;
        tick(); tick();
        read_ready = 1'b0;
        tick();
        checks++; if (row_sel !== 5'd2) begin errors++; $display("FAIL row_advance got=%0d want=2", row_sel); end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, read_valid, frame_done, row_sel} !== 8'b0) begin
            errors++;
            $display("FAIL reset_mid_read got=%b want=0", {busy, read_valid, frame_done, row_sel});
        end
        reset = 1'b1;
        read_ready = 1'b1;
        tick();
        $display("test_reset_mid_read: errors=%0d", errors);
    endtask

    task automatic test_back_to_back();
        run_frame(16'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || erase_line !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b%b want=00", busy, erase_line); end
        tick();
        checks++; if (busy !== 1'b1 || erase_line !== 1'b1) begin errors++; $display("FAIL b2b_restart got=%b%b want=11", busy, erase_line); end
        start = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        $display("test_back_to_back: errors=%0d", errors);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        expose_time = '0;
        read_ready = 1'b1;
        test_reset();
        test_nominal_frame();
        test_pixel_array();
        test_zero_expose();
        test_random_ready();
        test_start_while_busy();
        test_reset_mid_convert();
        test_reset_mid_read();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
